alu_sequencer: RTL and testbench

- Multi-cycle instruction sequencer that owns an internal register file and drives the 8-bit combinational ALU (opcodes add/sub/and/or/xor/mul/div/cmp).
- Accepts one instruction per valid/ready handshake, reads operands, drives the ALU, captures the result and writes it back.
- Sits between an instruction source (testbench or future fetch unit) and the ALU. Replaces the ad-hoc control_unit pass-through.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/seq_regfile.sv | 42 ++++
 rtl/alu_sequencer.sv | 169 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU sequencer.
//   - ALU opcode constants (alu_sel encoding)
//   - sequencer FSM state encoding
//   - instruction field bit positions for the 16-bit instruction word
package alu_pkg;

    localparam int unsigned INSTR_W  = 16;
    localparam int unsigned OP_W     = 3;

    // ALU opcodes
    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_MUL = 3'b101;
    localparam logic [OP_W-1:0] OP_DIV = 3'b110;
    localparam logic [OP_W-1:0] OP_CMP = 3'b111;

    // Instruction field positions
    localparam int unsigned OP_MSB   = 15;
    localparam int unsigned OP_LSB   = 13;
    localparam int unsigned IMM_BIT  = 12;
    localparam int unsigned RD_MSB   = 11;
    localparam int unsigned RD_LSB   = 10;
    localparam int unsigned RS1_MSB  = 9;
    localparam int unsigned RS1_LSB  = 8;
    localparam int unsigned RS2_MSB  = 1;
    localparam int unsigned RS2_LSB  = 0;
    localparam int unsigned IMM8_MSB = 7;
    localparam int unsigned IMM8_LSB = 0;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_RETIRE = 2'd2
    } seq_state_t;

    // Opcodes whose ALU carry is meaningful for the carry flag
    function automatic logic op_has_carry(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/seq_regfile.sv
// seq_regfile: 2**REG_AW x DATA_W register file.
//   clk, reset      : clock, synchronous active-high reset (clears all entries)
//   i_we/i_waddr/i_wdata : synchronous write port
//   i_raddr_a/b, o_rdata_a_c/o_rdata_b_c : combinational operand read ports
//   i_dbg_addr, o_dbg_data_c              : combinational debug read port
module seq_regfile #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned REG_AW = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [REG_AW-1:0] i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a_c,
    input  logic [REG_AW-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b_c,
    input  logic [REG_AW-1:0] i_dbg_addr,
    output logic [DATA_W-1:0] o_dbg_data_c
);

    localparam int unsigned DEPTH = 2 ** REG_AW;

    logic [DATA_W-1:0] r_regs [DEPTH];

    // Storage with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a_c  = r_regs[i_raddr_a];
    assign o_rdata_b_c  = r_regs[i_raddr_b];
    assign o_dbg_data_c = r_regs[i_dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: three-cycle instruction sequencer around an external 8-bit ALU.
//   clk, reset                 : clock, synchronous active-high reset
//   instr_valid/instr_ready    : instruction handshake; instr is the 16-bit word
//   alu_a/alu_b/alu_sel        : registered operands and opcode to the ALU
//   alu_out/alu_carry          : combinational ALU result
//   done/err                   : one-cycle retire / divide-by-zero pulses
//   result                     : last value written back
//   dbg_addr/dbg_data          : combinational register file debug read
//   flag_z/flag_c              : zero/carry flags, built only when ALU_SEQ_FLAGS_EN
//                                is defined, otherwise tied to 0
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned REG_AW = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [OP_W-1:0]    alu_sel,
    input  logic [DATA_W-1:0]  alu_out,
    input  logic               alu_carry,
    output logic               done,
    output logic               err,
    output logic [DATA_W-1:0]  result,
    input  logic [REG_AW-1:0]  dbg_addr,
    output logic [DATA_W-1:0]  dbg_data,
    output logic               flag_z,
    output logic               flag_c
);

    seq_state_t        r_state;
    seq_state_t        w_next_state;
    logic              w_accept;
    logic              w_div0;
    logic              w_we;

    logic              r_ready;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [OP_W-1:0]   r_alu_sel;
    logic [REG_AW-1:0] r_rd;
    logic              r_done;
    logic              r_err;
    logic [DATA_W-1:0] r_result;

    logic [REG_AW-1:0] w_rs1;
    logic [REG_AW-1:0] w_rs2;
    logic [DATA_W-1:0] w_rdata_a;
    logic [DATA_W-1:0] w_rdata_b;
    logic [DATA_W-1:0] w_imm8;
    logic              w_imm;

    // Instruction field decode
    assign w_rs1  = REG_AW'(instr[RS1_MSB:RS1_LSB]);
    assign w_rs2  = REG_AW'(instr[RS2_MSB:RS2_LSB]);
    assign w_imm  = instr[IMM_BIT];
    assign w_imm8 = DATA_W'(instr[IMM8_MSB:IMM8_LSB]);

    seq_regfile #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk          (clk),
        .reset        (reset),
        .i_we         (w_we),
        .i_waddr      (r_rd),
        .i_wdata      (alu_out),
        .i_raddr_a    (w_rs1),
        .o_rdata_a_c  (w_rdata_a),
        .i_raddr_b    (w_rs2),
        .o_rdata_b_c  (w_rdata_b),
        .i_dbg_addr   (dbg_addr),
        .o_dbg_data_c (dbg_data)
    );

    // Next-state and per-cycle control decode
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_div0       = 1'b0;
        w_we         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (instr_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_div0       = (r_alu_sel == OP_DIV) && (r_alu_b == '0);
                w_we         = !w_div0;
                w_next_state = ST_RETIRE;
            end
            ST_RETIRE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register and registered outputs; ready tracks the upcoming state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_ready   <= 1'b1;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_sel <= '0;
            r_rd      <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_result  <= '0;
        end else begin
            r_state <= w_next_state;
            r_ready <= (w_next_state == ST_IDLE);
            r_done  <= w_we;
            r_err   <= w_div0;
            if (w_accept) begin
                r_alu_a   <= w_rdata_a;
                r_alu_b   <= w_imm ? w_imm8 : w_rdata_b;
                r_alu_sel <= instr[OP_MSB:OP_LSB];
                r_rd      <= REG_AW'(instr[RD_MSB:RD_LSB]);
            end
            if (w_we) begin
                r_result <= alu_out;
            end
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic r_flag_z;
    logic r_flag_c;

    // Flags follow successful retires only
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flag_z <= 1'b0;
            r_flag_c <= 1'b0;
        end else if (w_we) begin
            r_flag_z <= (alu_out == '0);
            r_flag_c <= op_has_carry(r_alu_sel) ? alu_carry : 1'b0;
        end
    end

    assign flag_z = r_flag_z;
    assign flag_c = r_flag_c;
`else
    logic w_unused_carry;
    assign w_unused_carry = alu_carry;
    assign flag_z         = 1'b0;
    assign flag_c         = 1'b0;
`endif

    assign instr_ready = r_ready;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_sel     = r_alu_sel;
    assign done        = r_done;
    assign err         = r_err;
    assign result      = r_result;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer with a behavioural 8-bit ALU beside it and a
// register-file reference model. Flag checks follow ALU_SEQ_FLAGS_EN.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_sel;
    logic [7:0]  alu_out;
    logic        alu_carry;
    logic        done;
    logic        err;
    logic [7:0]  result;
    logic [1:0]  dbg_addr;
    logic [7:0]  dbg_data;
    logic        flag_z;
    logic        flag_c;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state
    logic [7:0] ref_regs [4];
    logic [7:0] ref_result;
    logic       ref_z;
    logic       ref_c;

    always #5 clk = ~clk;

    alu_sequencer #(.DATA_W(8), .REG_AW(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_out     (alu_out),
        .alu_carry   (alu_carry),
        .done        (done),
        .err         (err),
        .result      (result),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .flag_z      (flag_z),
        .flag_c      (flag_c)
    );

    // Behavioural ALU: {carry, result}
    function automatic logic [8:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        case (op)
            3'd0: return {1'b0, a} + {1'b0, b};
            3'd1: return {(a < b), 8'(a - b)};
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a ^ b};
            3'd5: begin
                p = 16'(a) * 16'(b);
                return {(p[15:8] != 8'h00), p[7:0]};
            end
            3'd6: return (b == 8'h00) ? 9'h0FF : {1'b0, 8'(a / b)};
            default: return {1'b0, 7'h00, (a < b)};
        endcase
    endfunction

    always_comb {alu_carry, alu_out} = alu_fn(alu_sel, alu_a, alu_b);

    function automatic logic [15:0] mk(input logic [2:0] op, input logic imm, input logic [1:0] rd,
                                       input logic [1:0] rs1, input logic [7:0] low);
        return {op, imm, rd, rs1, low};
    endfunction

    // Expected flags given the build
    function automatic logic exp_z();
`ifdef ALU_SEQ_FLAGS_EN
        return ref_z;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic exp_c();
`ifdef ALU_SEQ_FLAGS_EN
        return ref_c;
`else
        return 1'b0;
`endif
    endfunction

    // Apply one instruction to the reference model; returns 1 on divide-by-zero
    function automatic logic model_exec(input logic [15:0] ins);
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] v;
        op = ins[15:13];
        a  = ref_regs[ins[9:8]];
        b  = ins[12] ? ins[7:0] : ref_regs[ins[1:0]];
        if (op == 3'd6 && b == 8'h00) return 1'b1;
        v = alu_fn(op, a, b);
        ref_regs[ins[11:10]] = v[7:0];
        ref_result = v[7:0];
        ref_z = (v[7:0] == 8'h00);
        ref_c = (op == 3'd0 || op == 3'd1 || op == 3'd5) ? v[8] : 1'b0;
        return 1'b0;
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            n_cmp++;
            if (dbg_data !== ref_regs[i]) begin
                n_err++;
                $display("FAIL %s r%0d: got %h expected %h", tag, i, dbg_data, ref_regs[i]);
            end
        end
    endtask

    // Issue one instruction and check all three cycles of its execution
    task automatic issue(input logic [15:0] ins);
        int         w;
        logic       div0;
        logic [7:0] ea;
        logic [7:0] eb;
        w = 0;
        while (instr_ready !== 1'b1 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 20) begin
            n_cmp++; n_err++;
            $display("FAIL issue_timeout: ready=%b expected 1", instr_ready);
            return;
        end
        ea = ref_regs[ins[9:8]];
        eb = ins[12] ? ins[7:0] : ref_regs[ins[1:0]];
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        n_cmp += 4;
        if (alu_a !== ea)          begin n_err++; $display("FAIL alu_a: got %h expected %h", alu_a, ea); end
        if (alu_b !== eb)          begin n_err++; $display("FAIL alu_b: got %h expected %h", alu_b, eb); end
        if (alu_sel !== ins[15:13]) begin n_err++; $display("FAIL alu_sel: got %h expected %h", alu_sel, ins[15:13]); end
        if (instr_ready !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL exec_ctrl: ready=%b done=%b expected 0/0", instr_ready, done);
        end
        div0 = model_exec(ins);
        dbg_addr = ins[11:10];
        @(posedge clk); #1;
        n_cmp += 5;
        if (done !== !div0)   begin n_err++; $display("FAIL done: got %b expected %b", done, !div0); end
        if (err !== div0)     begin n_err++; $display("FAIL err: got %b expected %b", err, div0); end
        if (result !== ref_result) begin n_err++; $display("FAIL result: got %h expected %h", result, ref_result); end
        if (dbg_data !== ref_regs[ins[11:10]]) begin
            n_err++; $display("FAIL rd_write: got %h expected %h", dbg_data, ref_regs[ins[11:10]]);
        end
        if (flag_z !== exp_z() || flag_c !== exp_c()) begin
            n_err++; $display("FAIL flags: got z=%b c=%b expected z=%b c=%b", flag_z, flag_c, exp_z(), exp_c());
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || err !== 1'b0 || instr_ready !== 1'b1) begin
            n_err++; $display("FAIL retire_end: done=%b err=%b ready=%b expected 0/0/1", done, err, instr_ready);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) ref_regs[i] = 8'h00;
        ref_result = 8'h00;
        ref_z = 1'b0;
        ref_c = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        instr_valid = 1'b0;
        instr = 16'h0000;
        dbg_addr = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        n_cmp++;
        if (instr_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || result !== 8'h00 ||
            alu_a !== 8'h00 || alu_b !== 8'h00 || alu_sel !== 3'd0 || flag_z !== 1'b0 || flag_c !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: ready=%b done=%b err=%b result=%h a=%h b=%h sel=%h z=%b c=%b expected 1/0/0/00/00/00/0/0/0",
                     instr_ready, done, err, result, alu_a, alu_b, alu_sel, flag_z, flag_c);
        end
        check_regs("reset");
    endtask

    task automatic test_load();
        issue(mk(3'd0, 1'b1, 2'd1, 2'd0, 8'h05));
        check_regs("load");
    endtask

    task automatic test_reg_ops();
        issue(mk(3'd0, 1'b1, 2'd1, 2'd0, 8'hFF));
        issue(mk(3'd0, 1'b1, 2'd2, 2'd0, 8'h01));
        issue(mk(3'd0, 1'b0, 2'd3, 2'd1, 8'h02));
        issue(mk(3'd1, 1'b0, 2'd0, 2'd2, 8'h01));
        check_regs("reg_ops");
    endtask

    task automatic test_div0();
        issue(mk(3'd0, 1'b1, 2'd1, 2'd2, 8'h0F));
        issue(mk(3'd2, 1'b1, 2'd0, 2'd0, 8'h00));
        issue(mk(3'd6, 1'b0, 2'd2, 2'd1, 8'h00));
        issue(mk(3'd6, 1'b1, 2'd3, 2'd1, 8'h00));
        check_regs("div0");
    endtask

    task automatic test_back_to_back();
        logic [15:0] q [3];
        int idx;
        int accepts;
        int dones;
        logic rdy;
        logic d;
        issue(mk(3'd0, 1'b1, 2'd1, 2'd0, 8'h03));
        issue(mk(3'd0, 1'b1, 2'd2, 2'd0, 8'h60));
        q[0] = mk(3'd7, 1'b0, 2'd0, 2'd1, 8'h02);
        q[1] = mk(3'd4, 1'b0, 2'd3, 2'd1, 8'h02);
        q[2] = mk(3'd5, 1'b0, 2'd1, 2'd1, 8'h02);
        for (int i = 0; i < 3; i++) d = model_exec(q[i]);
        idx = 0; accepts = 0; dones = 0;
        instr = q[0];
        instr_valid = 1'b1;
        for (int c = 0; c < 9; c++) begin
            rdy = instr_ready;
            @(posedge clk); #1;
            if (rdy && idx < 3) begin
                accepts++;
                idx++;
                if (idx < 3) instr = q[idx];
                else instr_valid = 1'b0;
            end
            if (done === 1'b1) dones++;
        end
        instr_valid = 1'b0;
        n_cmp += 2;
        if (accepts !== 3 || dones !== 3) begin
            n_err++; $display("FAIL b2b_count: accepts=%0d dones=%0d expected 3/3", accepts, dones);
        end
        if (instr_ready !== 1'b1 || result !== ref_result) begin
            n_err++; $display("FAIL b2b_end: ready=%b result=%h expected 1/%h", instr_ready, result, ref_result);
        end
        check_regs("b2b");
    endtask

    task automatic test_reset_in_exec();
        issue(mk(3'd0, 1'b1, 2'd2, 2'd0, 8'h77));
        instr = mk(3'd0, 1'b1, 2'd3, 2'd0, 8'h42);
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        n_cmp++;
        if (done !== 1'b0 || err !== 1'b0 || instr_ready !== 1'b1 || result !== 8'h00 || alu_a !== 8'h00) begin
            n_err++;
            $display("FAIL reset_exec: done=%b err=%b ready=%b result=%h a=%h expected 0/0/1/00/00",
                     done, err, instr_ready, result, alu_a);
        end
        check_regs("reset_exec");
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || err !== 1'b0) begin
            n_err++; $display("FAIL reset_exec_late: done=%b err=%b expected 0/0", done, err);
        end
    endtask

    task automatic test_valid_toggle();
        logic [15:0] a_ins;
        logic d;
        a_ins = mk(3'd0, 1'b1, 2'd2, 2'd0, 8'($urandom_range(1, 255)));
        instr = a_ins;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        d = model_exec(a_ins);
        for (int c = 0; c < 2; c++) begin
            instr_valid = 1'($urandom_range(0, 1)) | (c == 0);
            instr = mk(3'd0, 1'b1, 2'd3, 2'd0, 8'hA5);
            n_cmp++;
            if (instr_ready !== 1'b0) begin
                n_err++; $display("FAIL busy_ready: got %b expected 0", instr_ready);
            end
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (instr_ready !== 1'b1 || done !== 1'b0 || result !== ref_result) begin
            n_err++; $display("FAIL toggle_end: ready=%b done=%b result=%h expected 1/0/%h",
                              instr_ready, done, result, ref_result);
        end
        check_regs("toggle");
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            issue(16'($urandom));
        end
        check_regs("random");
    endtask

    initial begin
        test_reset();
        test_load();
        test_reg_ops();
        test_div0();
        test_back_to_back();
        test_reset_in_exec();
        test_valid_toggle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
